// File: rtl/inst_fetch.sv
// inst_fetch: OpenMIPS instruction-fetch front end.
// Owns the PC, drives the ROM port and loads the IF/ID register.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_stall,
  input  logic        id_stall,
  input  logic        flush,
  input  logic [31:0] new_pc,
  input  logic        branch_flag,
  input  logic [31:0] branch_target,
  output logic        rom_ce,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_inst,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst,
  output logic        id_valid,
  output logic        id_misalign
);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        valid;
    logic        misalign;
  } if_id_t;

  logic [31:0] pc;
  logic [31:0] pc_nxt;
  if_id_t      if_id;
  if_id_t      if_id_nxt;
  if_id_t      if_id_clr;
  logic        pc_odd;

  assign rom_addr    = pc;
  assign pc_odd      = pc[1:0] != 2'b00;
  assign id_pc       = if_id.pc;
  assign id_inst     = if_id.inst;
  assign id_valid    = if_id.valid;
  assign id_misalign = if_id.misalign;

  assign if_id_clr = '{pc: 32'h0, inst: NOP_INST,
                       valid: 1'b0, misalign: 1'b0};

  // Stalled branches are dropped; ID re-presents them after the stall.
  always_comb begin
    pc_nxt = pc + 32'd4;
    if (!rom_ce)
      pc_nxt = pc;
    else if (flush)
      pc_nxt = new_pc;
    else if (if_stall)
      pc_nxt = pc;
    else if (branch_flag)
      pc_nxt = branch_target;
  end

  always_comb begin
    if_id_nxt.pc       = pc;
    if_id_nxt.valid    = rom_ce;
    if_id_nxt.misalign = rom_ce & pc_odd;
    if_id_nxt.inst     = (rom_ce && !pc_odd) ? rom_inst : NOP_INST;
    if (flush)
      if_id_nxt = if_id_clr;
    else if (if_stall && !id_stall)
      if_id_nxt = if_id_clr;
    else if (id_stall)
      if_id_nxt = if_id;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rom_ce <= 1'b0;
      pc     <= RESET_PC;
      if_id  <= if_id_clr;
    end else begin
      rom_ce <= 1'b1;
      pc     <= pc_nxt;
      if_id  <= if_id_nxt;
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: directed vectors for inst_fetch.
// ROM model returns a word derived from its address.
module tb_inst_fetch;

  logic        clk;
  logic        rst;
  logic        if_stall;
  logic        id_stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        branch_flag;
  logic [31:0] branch_target;
  logic        rom_ce;
  logic [31:0] rom_addr;
  logic [31:0] rom_inst;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_valid;
  logic        id_misalign;

  int checks;
  int failures;

  inst_fetch dut (
    .clk           (clk),
    .rst           (rst),
    .if_stall      (if_stall),
    .id_stall      (id_stall),
    .flush         (flush),
    .new_pc        (new_pc),
    .branch_flag   (branch_flag),
    .branch_target (branch_target),
    .rom_ce        (rom_ce),
    .rom_addr      (rom_addr),
    .rom_inst      (rom_inst),
    .id_pc         (id_pc),
    .id_inst       (id_inst),
    .id_valid      (id_valid),
    .id_misalign   (id_misalign)
  );

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return 32'hA500_0000 ^ a;
  endfunction

  assign rom_inst = rom_word(rom_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_id(input string tag,
                        input logic [31:0] pc,
                        input logic [31:0] inst,
                        input logic        vld,
                        input logic        mis);
    chk({tag, ".id_pc"}, id_pc, pc);
    chk({tag, ".id_inst"}, id_inst, inst);
    chk({tag, ".id_valid"}, {31'b0, id_valid}, {31'b0, vld});
    chk({tag, ".id_mis"}, {31'b0, id_misalign}, {31'b0, mis});
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    if_stall = 1'b0;
    id_stall = 1'b0;
    flush = 1'b0;
    new_pc = 32'h0;
    branch_flag = 1'b0;
    branch_target = 32'h0;
    #2;
    chk("rst.ce", {31'b0, rom_ce}, 32'h0);
    chk("rst.addr", rom_addr, 32'h0);
    chk_id("rst", 32'h0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    step();
    chk("e1.ce", {31'b0, rom_ce}, 32'h1);
    chk("e1.addr", rom_addr, 32'h0);
    chk_id("e1", 32'h0, 32'h0, 1'b0, 1'b0);
    step();
    chk("e2.addr", rom_addr, 32'h4);
    chk_id("e2", 32'h0, rom_word(32'h0), 1'b1, 1'b0);
    step();
    chk("e3.addr", rom_addr, 32'h8);
    chk_id("e3", 32'h4, rom_word(32'h4), 1'b1, 1'b0);

    branch_flag = 1'b1;
    branch_target = 32'h40;
    step();
    branch_flag = 1'b0;
    chk("br.addr", rom_addr, 32'h40);
    chk_id("br.slot", 32'h8, rom_word(32'h8), 1'b1, 1'b0);
    step();
    chk("br.addr2", rom_addr, 32'h44);
    chk_id("br.tgt", 32'h40, rom_word(32'h40), 1'b1, 1'b0);

    branch_flag = 1'b1;
    branch_target = 32'h10;
    step();
    branch_flag = 1'b0;
    chk("go16.addr", rom_addr, 32'h10);

    if_stall = 1'b1;
    branch_flag = 1'b1;
    branch_target = 32'h300;
    step();
    chk("ifs1.addr", rom_addr, 32'h10);
    chk_id("ifs1", 32'h0, 32'h0, 1'b0, 1'b0);
    branch_flag = 1'b0;
    step();
    chk("ifs2.addr", rom_addr, 32'h10);
    chk_id("ifs2", 32'h0, 32'h0, 1'b0, 1'b0);
    if_stall = 1'b0;
    step();
    chk("ifs3.addr", rom_addr, 32'h14);
    chk_id("ifs3", 32'h10, rom_word(32'h10), 1'b1, 1'b0);

    if_stall = 1'b1;
    id_stall = 1'b1;
    step();
    chk("hold.addr", rom_addr, 32'h14);
    chk_id("hold", 32'h10, rom_word(32'h10), 1'b1, 1'b0);
    if_stall = 1'b0;
    id_stall = 1'b0;
    step();
    chk("rel.addr", rom_addr, 32'h18);
    chk_id("rel", 32'h14, rom_word(32'h14), 1'b1, 1'b0);

    id_stall = 1'b1;
    step();
    id_stall = 1'b0;
    chk("ids.addr", rom_addr, 32'h1C);
    chk_id("ids", 32'h14, rom_word(32'h14), 1'b1, 1'b0);

    flush = 1'b1;
    new_pc = 32'h20;
    branch_flag = 1'b1;
    branch_target = 32'h80;
    if_stall = 1'b1;
    step();
    flush = 1'b0;
    branch_flag = 1'b0;
    if_stall = 1'b0;
    chk("fl.addr", rom_addr, 32'h20);
    chk_id("fl", 32'h0, 32'h0, 1'b0, 1'b0);
    step();
    chk("fl2.addr", rom_addr, 32'h24);
    chk_id("fl2", 32'h20, rom_word(32'h20), 1'b1, 1'b0);

    branch_flag = 1'b1;
    branch_target = 32'h42;
    step();
    branch_flag = 1'b0;
    chk("mis.addr", rom_addr, 32'h42);
    step();
    chk("mis.addr2", rom_addr, 32'h46);
    chk_id("mis", 32'h42, 32'h0, 1'b1, 1'b1);
    step();
    chk("mis.addr3", rom_addr, 32'h4A);
    chk_id("mis2", 32'h46, 32'h0, 1'b1, 1'b1);

    flush = 1'b1;
    new_pc = 32'hFFFF_FFFC;
    step();
    flush = 1'b0;
    chk("wrap.addr", rom_addr, 32'hFFFF_FFFC);
    chk_id("wrap.fl", 32'h0, 32'h0, 1'b0, 1'b0);
    step();
    chk("wrap.addr2", rom_addr, 32'h0);
    chk_id("wrap", 32'hFFFF_FFFC, rom_word(32'hFFFF_FFFC), 1'b1, 1'b0);
    step();
    chk("wrap.addr3", rom_addr, 32'h4);

    #2;
    rst = 1'b1;
    #1;
    chk("mrst.ce", {31'b0, rom_ce}, 32'h0);
    chk("mrst.addr", rom_addr, 32'h0);
    chk_id("mrst", 32'h0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    step();
    chk("r1.ce", {31'b0, rom_ce}, 32'h1);
    chk("r1.addr", rom_addr, 32'h0);
    chk_id("r1", 32'h0, 32'h0, 1'b0, 1'b0);
    step();
    chk("r2.addr", rom_addr, 32'h4);
    chk_id("r2", 32'h0, rom_word(32'h0), 1'b1, 1'b0);
    step();
    chk("r3.addr", rom_addr, 32'h8);
    chk_id("r3", 32'h4, rom_word(32'h4), 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
- Instruction-fetch front end of the OpenMIPS pipeline; the initiator side of the instruction ROM interface.
- Holds the PC and drives the ROM chip-enable and address; the ROM returns its word combinationally in the same cycle.
- Registers {pc, inst, valid} into the IF/ID pipeline register.
- Handles stalls, delay-slot branch redirect, exception flush, PC wrap and misaligned-target marking.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded by reset.
- NOP_INST, 32'h0000_0000, instruction injected for bubbles and flushes.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- if_stall  input  1  ctrl stall request for the IF stage.
- id_stall  input  1  ctrl stall request for the ID stage.
- flush  input  1  exception flush from ctrl.
- new_pc  input  32  exception handler / ERET target, valid with flush.
- branch_flag  input  1  taken branch/jump resolved in ID.
- branch_target  input  32  branch/jump destination.
- rom_ce  output  1  ROM chip enable (1 = enabled).
- rom_addr  output  32  byte address to ROM; equals the PC.
- rom_inst  input  32  instruction word from ROM, combinational from rom_addr.
- id_pc  output  32  registered PC of the instruction in ID.
- id_inst  output  32  registered instruction to ID.
- id_valid  output  1  id_inst is a real fetched instruction.
- id_misalign  output  1  id_pc low two bits nonzero (fetch address error).

Behaviour:
- Reset (async, any time): rom_ce=0, pc=RESET_PC, id_pc=0, id_inst=NOP_INST, id_valid=0, id_misalign=0. Effect is immediate, not on the next edge.
- rom_addr = pc at all times.
- rom_ce: first rising edge after rst deasserts sets rom_ce=1; it stays 1 until the next reset.
- PC update at each rising edge, highest priority first:
  1. rom_ce==0: pc holds.
  2. flush: pc=new_pc.
  3. if_stall: pc holds; branch_flag is ignored in this cycle, and ID re-presents the branch after the stall.
  4. branch_flag: pc=branch_target.
  5. Otherwise: pc=pc+4, modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
- Delay slot: the instruction fetched in the cycle branch_flag is asserted is the delay slot. It enters IF/ID normally and is never squashed.
- IF/ID register update at each rising edge, highest priority first:
  1. flush: id_pc=0, id_inst=NOP_INST, id_valid=0, id_misalign=0.
  2. if_stall and !id_stall: bubble. Same values as flush.
  3. id_stall: all id_* outputs hold.
  4. Otherwise: id_pc=pc, id_valid=rom_ce, id_misalign=rom_ce & (pc[1:0]!=0).
     - id_inst = NOP_INST if rom_ce==0 or pc[1:0]!=0; else rom_inst.
- Misaligned target: pc loads the value unmodified. Fetch continues sequentially from it (pc+4 keeps the same low bits). The exception unit must flush on id_misalign; this block does not self-correct.
- Latency: an instruction at PC X appears on id_inst one cycle after rom_addr=X, absent stalls.
- Simultaneous events:
  - flush beats branch_flag and both stalls.
  - if_stall with id_stall: full hold of pc and IF/ID.
  - id_stall without if_stall is illegal from ctrl. If it occurs, pc advances and IF/ID holds; the bench flags it.

Test Plan:
- Reset release, no stalls → rom_ce=1 on edge 1; rom_addr 0,4,8,12. id_inst = ROM words 0,1,2 one cycle later; id_valid=1 from edge 2.
- branch_flag=1, target=32'h40, in the cycle rom_addr=8 → addr 8 (delay slot) reaches ID with valid=1; the next addresses are 32'h40, 32'h44.
- if_stall=1, id_stall=0 for 2 cycles at rom_addr=16 → rom_addr held at 16; id_valid=0 and id_inst=0 for 2 cycles; then addr 16 reaches ID.
- flush=1, new_pc=32'h20 together with branch_flag=1, target=32'h80 → next rom_addr=32'h20; IF/ID cleared (id_valid=0).
- branch_target=32'h42 → id_misalign=1, id_inst=0, id_pc=32'h42; next rom_addr=32'h46. Separately, pc=32'hFFFF_FFFC → next rom_addr=0.
- Assert rst mid-stream between clock edges → rom_ce=0, id_valid=0, rom_addr=RESET_PC immediately. Fetch restarts as in the first scenario after release.
